// File: rtl/mem_ctrl_pkg.sv
// Shared memory types for the cache-to-main-memory controller: block data/address
// types, request type and controller FSM state.
package mem_ctrl_pkg;

   localparam int unsigned BLOCK_WIDTH      = 64;
   localparam int unsigned BLOCK_ADDR_WIDTH = 32;

   typedef logic [BLOCK_WIDTH-1:0]      block_data_t;
   typedef logic [BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;

   typedef enum logic {
      ReqRead  = 1'b0,
      ReqWrite = 1'b1
   } req_type_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } mem_ctrl_state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache-side request/response bundle for mem_ctrl: icache read port and dcache
// read/write port. master = caches, slave = memory controller.
interface mem_ctrl_if;
   import mem_ctrl_pkg::*;

   logic                 icache_req_valid;
   logic                 icache_req_ready;
   main_mem_block_addr_t icache_req_block_addr;
   logic                 icache_resp_valid;
   block_data_t          icache_resp_block_data;

   logic                 dcache_req_valid;
   logic                 dcache_req_ready;
   req_type_t            dcache_req_type;
   main_mem_block_addr_t dcache_req_block_addr;
   block_data_t          dcache_req_block_data;
   logic                 dcache_resp_valid;
   block_data_t          dcache_resp_block_data;

   modport master (
      output icache_req_valid, icache_req_block_addr,
      input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
      output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
      input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
   );

   modport slave (
      input  icache_req_valid, icache_req_block_addr,
      output icache_req_ready, icache_resp_valid, icache_resp_block_data,
      input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
      output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
   );

endinterface

// File: rtl/mem_ctrl_block_array.sv
// Single-port backing store. One access per enable; a write returns the written
// block so the controller can use it as the write acknowledge.
module mem_ctrl_block_array
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 1024,
   parameter int unsigned IDX_W      = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  block_data_t      wdata,
   output block_data_t      rdata
);

   block_data_t mem [NUM_BLOCKS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller: one pending slot per cache port, icache-first service,
// fixed MEM_LATENCY wait. Define MEM_CTRL_PERF_EN to add accepted-request counters.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 4,
   parameter int unsigned NUM_BLOCKS  = 1024
) (
   input  logic        clk,
   input  logic        rst_aH,
   mem_ctrl_if.slave   bus
`ifdef MEM_CTRL_PERF_EN
   ,
   output logic [31:0] icache_req_count,
   output logic [31:0] dcache_req_count
`endif
);

   localparam int unsigned IDX_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam logic [7:0]  CNT_LOAD = 8'(MEM_LATENCY - 1);

   typedef logic [IDX_W-1:0] idx_t;

   mem_ctrl_state_t state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            sel_dc_q, sel_dc_d;
   logic            served_q;
   logic            access;

   logic            i_valid_q;
   idx_t            i_addr_q;
   logic            d_valid_q;
   req_type_t       d_type_q;
   idx_t            d_addr_q;
   block_data_t     d_data_q;

   logic            i_fire, d_fire;
   logic            i_resp, d_resp;
   logic            arr_we;
   idx_t            arr_addr;
   block_data_t     rd_data, i_hold_q, d_hold_q;
   logic            unused_addr_hi;

   // Address bits above the array index are dropped, so addresses wrap.
   assign unused_addr_hi = ^{bus.icache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W],
                             bus.dcache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W]};

   assign i_fire = bus.icache_req_valid & ~i_valid_q;
   assign d_fire = bus.dcache_req_valid & ~d_valid_q;
   assign bus.icache_req_ready = ~i_valid_q;
   assign bus.dcache_req_ready = ~d_valid_q;

   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         i_valid_q <= 1'b0;
         i_addr_q  <= '0;
         d_valid_q <= 1'b0;
         d_type_q  <= ReqRead;
         d_addr_q  <= '0;
         d_data_q  <= '0;
      end else begin
         if (i_fire) begin
            i_valid_q <= 1'b1;
            i_addr_q  <= bus.icache_req_block_addr[IDX_W-1:0];
         end else if (access && !sel_dc_q) begin
            i_valid_q <= 1'b0;
         end
         if (d_fire) begin
            d_valid_q <= 1'b1;
            d_type_q  <= bus.dcache_req_type;
            d_addr_q  <= bus.dcache_req_block_addr[IDX_W-1:0];
            d_data_q  <= bus.dcache_req_block_data;
         end else if (access && sel_dc_q) begin
            d_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sel_dc_q <= 1'b0;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_dc_q <= sel_dc_d;
         served_q <= (state_q == StResp);
      end
   end

   // The IDLE cycle right after a response still belongs to that service, so a
   // waiting slot is only picked up on the following IDLE cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_dc_d = sel_dc_q;
      access   = 1'b0;
      case (state_q)
         StIdle: begin
            if (!served_q && (i_valid_q || d_valid_q)) begin
               sel_dc_d = ~i_valid_q;
               cnt_d    = CNT_LOAD;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               access  = 1'b1;
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign arr_we   = access & sel_dc_q & (d_type_q == ReqWrite);
   assign arr_addr = sel_dc_q ? d_addr_q : i_addr_q;

   mem_ctrl_block_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .IDX_W      (IDX_W)
   ) u_block_array (
      .clk   (clk),
      .en    (access),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (d_data_q),
      .rdata (rd_data)
   );

   assign i_resp = (state_q == StResp) & ~sel_dc_q;
   assign d_resp = (state_q == StResp) & sel_dc_q;

   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         i_hold_q <= '0;
         d_hold_q <= '0;
      end else begin
         if (i_resp) i_hold_q <= rd_data;
         if (d_resp) d_hold_q <= rd_data;
      end
   end

   assign bus.icache_resp_valid      = i_resp;
   assign bus.dcache_resp_valid      = d_resp;
   assign bus.icache_resp_block_data = i_resp ? rd_data : i_hold_q;
   assign bus.dcache_resp_block_data = d_resp ? rd_data : d_hold_q;

`ifdef MEM_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         icache_req_count <= '0;
         dcache_req_count <= '0;
      end else begin
         if (i_fire) icache_req_count <= icache_req_count + 32'd1;
         if (d_fire) dcache_req_count <= dcache_req_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl (MEM_LATENCY=4, NUM_BLOCKS=1024); covers the
// MEM_CTRL_PERF_EN counters when that macro is defined.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int unsigned LAT = 4;
   localparam int unsigned NB  = 1024;

   typedef struct {
      block_data_t data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t iq[$];
   exp_t dq[$];

   mem_ctrl_if bus ();

`ifdef MEM_CTRL_PERF_EN
   logic [31:0] icnt, dcnt;
`endif

   mem_ctrl #(
      .MEM_LATENCY (LAT),
      .NUM_BLOCKS  (NB)
   ) dut (
      .clk    (clk),
      .rst_aH (rst),
      .bus    (bus)
`ifdef MEM_CTRL_PERF_EN
      ,
      .icache_req_count (icnt),
      .dcache_req_count (dcnt)
`endif
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Monitor: pop expected responses as the DUT presents them.
   always @(negedge clk) begin
      exp_t e;
      if (bus.icache_resp_valid && bus.dcache_resp_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL resp_exclusive: both resp_valid high, want at most one");
      end
      if (bus.icache_resp_valid) begin
         n_vec++;
         if (iq.size() == 0) begin
            n_err++;
            $display("FAIL icache_resp_unexpected: valid=1, want 0");
         end else begin
            e = iq.pop_front();
            if (bus.icache_resp_block_data !== e.data) begin
               n_err++;
               $display("FAIL icache_resp_data: got %h, want %h", bus.icache_resp_block_data, e.data);
            end
            if (e.cyc >= 0 && cyc != e.cyc) begin
               n_err++;
               $display("FAIL icache_resp_cycle: got %0d, want %0d", cyc, e.cyc);
            end
         end
      end
      if (bus.dcache_resp_valid) begin
         n_vec++;
         if (dq.size() == 0) begin
            n_err++;
            $display("FAIL dcache_resp_unexpected: valid=1, want 0");
         end else begin
            e = dq.pop_front();
            if (bus.dcache_resp_block_data !== e.data) begin
               n_err++;
               $display("FAIL dcache_resp_data: got %h, want %h", bus.dcache_resp_block_data, e.data);
            end
            if (e.cyc >= 0 && cyc != e.cyc) begin
               n_err++;
               $display("FAIL dcache_resp_cycle: got %0d, want %0d", cyc, e.cyc);
            end
         end
      end
   end

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic set_i(input main_mem_block_addr_t a);
      bus.icache_req_valid      = 1'b1;
      bus.icache_req_block_addr = a;
   endtask

   task automatic set_d(input req_type_t t, input main_mem_block_addr_t a, input block_data_t d);
      bus.dcache_req_valid      = 1'b1;
      bus.dcache_req_type       = t;
      bus.dcache_req_block_addr = a;
      bus.dcache_req_block_data = d;
   endtask

   // Called just after a rising edge with requests driven; returns one cycle later.
   // A latency < 0 means the response cycle is not checked; exp_* = 0 pushes nothing.
   task automatic commit(input bit exp_i, input block_data_t di, input int li,
                         input bit exp_d, input block_data_t dd, input int ld);
      exp_t e;
      @(negedge clk);
      if (bus.icache_req_valid) begin
         check("icache_req_ready", {63'd0, bus.icache_req_ready}, 64'd1);
         if (exp_i) begin
            e.data = di;
            e.cyc  = (li < 0) ? -1 : cyc + li;
            iq.push_back(e);
         end
      end
      if (bus.dcache_req_valid) begin
         check("dcache_req_ready", {63'd0, bus.dcache_req_ready}, 64'd1);
         if (exp_d) begin
            e.data = dd;
            e.cyc  = (ld < 0) ? -1 : cyc + ld;
            dq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      bus.icache_req_valid = 1'b0;
      bus.dcache_req_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((iq.size() != 0 || dq.size() != 0) && k < 60) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (iq.size() != 0 || dq.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d icache / %0d dcache responses outstanding, want 0",
                  iq.size(), dq.size());
         iq.delete();
         dq.delete();
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      check({tag, "_icache_req_ready"},  {63'd0, bus.icache_req_ready}, 64'd1);
      check({tag, "_dcache_req_ready"},  {63'd0, bus.dcache_req_ready}, 64'd1);
      check({tag, "_icache_resp_valid"}, {63'd0, bus.icache_resp_valid}, 64'd0);
      check({tag, "_dcache_resp_valid"}, {63'd0, bus.dcache_resp_valid}, 64'd0);
      check({tag, "_icache_resp_data"},  bus.icache_resp_block_data, 64'd0);
      check({tag, "_dcache_resp_data"},  bus.dcache_resp_block_data, 64'd0);
      @(posedge clk);
      #1;
   endtask

   localparam block_data_t D10    = 64'hA5A5_0000_1111_2222;
   localparam block_data_t D20    = 64'hDEAD_BEEF_0000_0001;
   localparam block_data_t D30    = 64'h3030_0000_0000_0030;
   localparam block_data_t D30BAD = 64'hBAD0_BAD0_BAD0_BAD0;
   localparam block_data_t D05    = 64'h0505_0505_0505_0505;

   initial begin
      bool_init();
      reset_dut();
      check_reset_state("rst0");

      // Preload blocks used later; ack returns the written block.
      set_d(ReqWrite, 32'h10, D10); commit(0, '0, -1, 1, D10, LAT + 2); drain();
      set_d(ReqWrite, 32'h30, D30); commit(0, '0, -1, 1, D30, -1); drain();
      set_d(ReqWrite, 32'h05, D05); commit(0, '0, -1, 1, D05, -1); drain();

      // Reset clears outputs but leaves the backing store intact.
      reset_dut();
      check_reset_state("rst1");

      // Single icache read: response exactly in cycle C+6.
      set_i(32'h10); commit(1, D10, LAT + 2, 0, '0, -1); drain();

      // dcache write then read-back.
      set_d(ReqWrite, 32'h20, D20); commit(0, '0, -1, 1, D20, LAT + 2); drain();
      set_d(ReqRead, 32'h20, '0);   commit(0, '0, -1, 1, D20, LAT + 2); drain();

      // Simultaneous requests: icache first at C+6, dcache at C+13.
      begin
         bit early_high = 1'b0;
         set_i(32'h10);
         set_d(ReqRead, 32'h20, '0);
         commit(1, D10, 6, 1, D20, 13);
         for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k < 13 && bus.dcache_req_ready) early_high = 1'b1;
            if (k == 13) check("dcache_ready_after_serve", {63'd0, bus.dcache_req_ready}, 64'd1);
         end
         check("dcache_ready_low_while_pending", {63'd0, early_high}, 64'd0);
         drain();
      end

      // Reset during WAIT of a write: no response, no array update.
      set_d(ReqWrite, 32'h30, D30BAD);
      commit(0, '0, -1, 0, '0, -1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_icache_ready", {63'd0, bus.icache_req_ready}, 64'd1);
      check("abort_dcache_ready", {63'd0, bus.dcache_req_ready}, 64'd1);
      repeat (12) @(negedge clk);
      @(posedge clk);
      #1;
      set_d(ReqRead, 32'h30, '0); commit(0, '0, -1, 1, D30, LAT + 2); drain();

      // Address wrap modulo NUM_BLOCKS.
      set_d(ReqRead, NB + 5, '0);        commit(0, '0, -1, 1, D05, -1); drain();
      set_i(32'h10 + 2 * NB);            commit(1, D10, -1, 0, '0, -1); drain();

`ifdef MEM_CTRL_PERF_EN
      reset_dut();
      for (int n = 0; n < 3; n++) begin
         set_i(32'h10); commit(1, D10, -1, 0, '0, -1); drain();
      end
      set_d(ReqWrite, 32'h40, 64'h4040); commit(0, '0, -1, 1, 64'h4040, -1); drain();
      set_d(ReqWrite, 32'h41, 64'h4141); commit(0, '0, -1, 1, 64'h4141, -1); drain();
      @(negedge clk);
      check("icache_req_count", {32'd0, icnt}, 64'd3);
      check("dcache_req_count", {32'd0, dcnt}, 64'd2);
      reset_dut();
      @(negedge clk);
      check("icache_req_count_rst", {32'd0, icnt}, 64'd0);
      check("dcache_req_count_rst", {32'd0, dcnt}, 64'd0);
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   task automatic bool_init();
      bus.icache_req_valid      = 1'b0;
      bus.icache_req_block_addr = '0;
      bus.dcache_req_valid      = 1'b0;
      bus.dcache_req_type       = ReqRead;
      bus.dcache_req_block_addr = '0;
      bus.dcache_req_block_data = '0;
   endtask

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4: number of WAIT cycles per access; legal range 1..255.
REQ-002 SHALL have parameter NUM_BLOCKS, default 1024: backing-store depth in blocks.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst_aH, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports icache_req_valid (input, 1) and icache_req_ready (output, 1): icache request handshake; icache issues reads only.
REQ-006 SHALL have port icache_req_block_addr, input, main_mem_block_addr_t: icache block address.
REQ-007 SHALL have ports icache_resp_valid (output, 1) and icache_resp_block_data (output, block_data_t): icache fill.
REQ-008 SHALL have ports dcache_req_valid (input, 1) and dcache_req_ready (output, 1): dcache request handshake.
REQ-009 SHALL have port dcache_req_type, input, req_type_t: 0 = read, 1 = write.
REQ-010 SHALL have ports dcache_req_block_addr (input, main_mem_block_addr_t) and dcache_req_block_data (input, block_data_t): dcache address and write data.
REQ-011 SHALL have ports dcache_resp_valid (output, 1) and dcache_resp_block_data (output, block_data_t): dcache fill or write acknowledge.

Function
REQ-012 SHALL hold one pending slot per port {valid, type, addr, data}; a request is captured when req_valid and req_ready are both high at a rising edge.
REQ-013 SHALL drive req_ready equal to NOT(slot valid) for that port; icache_req_ready is therefore always high whenever the icache has no outstanding request.
REQ-014 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE, serving one slot at a time.
REQ-015 IDLE: SHALL select the icache slot over the dcache slot when both are valid, latch the selection, load cnt = MEM_LATENCY-1 and enter WAIT; with no valid slot it SHALL stay in IDLE.
REQ-016 WAIT: SHALL decrement cnt while cnt != 0; at cnt == 0 the next edge SHALL enter RESP, perform the array read or write, and clear the served slot.
REQ-017 RESP: SHALL assert exactly one resp_valid (for the served port) for exactly one cycle, then return to IDLE.
REQ-018 In RESP, read data SHALL be the block at addr; write-ack data SHALL equal the block just written; the write SHALL be visible to any later-served read.
REQ-019 An unblocked request accepted in cycle C SHALL see resp_valid high in cycle C+MEM_LATENCY+2; a blocked request waits for the prior service to finish (RESP cycle plus the IDLE cycle).
REQ-020 SHALL NOT order accesses between ports; same-port accesses are strictly in issue order.
REQ-021 A capture into a slot in the same cycle its service ends SHALL NOT be possible, because ready is low while the slot is valid.
REQ-022 Block address bits above log2(NUM_BLOCKS) SHALL be ignored; the address wraps modulo NUM_BLOCKS.
REQ-023 resp_block_data SHALL hold its last value when resp_valid is low.

Reset
REQ-024 rst_aH SHALL asynchronously force: FSM = IDLE; cnt = 0; both slots invalid; resp_valid outputs = 0; resp_block_data outputs = 0; both req_ready outputs = 1 after release.
REQ-025 Reset mid-operation SHALL abort the in-flight access with no response and no array write; backing-store contents SHALL NOT be reset.

Configuration
REQ-026 Macro MEM_CTRL_PERF_EN defined SHALL add two 32-bit outputs, icache_req_count and dcache_req_count; each increments once per accepted request, wraps at 2^32, and is cleared by rst_aH.
REQ-027 Without MEM_CTRL_PERF_EN, those outputs and their counters SHALL be absent, with no other behavioural change.

Structure
REQ-028 req_type_t, block_data_t, main_mem_block_addr_t and the block-width constant SHALL come from the shared memory package; the FSM state enum SHALL be added there.
REQ-029 The backing store SHALL be one sub-module, mem_ctrl_block_array: single-port, synchronous write, read sampled on the WAIT->RESP edge.

Verification (MEM_LATENCY = 4)
REQ-030 Reset; icache read at addr 0x10, with block 0x10 preloaded to 0xA5A5_0000_1111_2222 in cycle 0 -> icache_resp_valid in cycle 6 only, data = preload, dcache_resp_valid stays 0.
REQ-031 dcache write of 0xDEAD_BEEF_0000_0001 to 0x20, then after the ack a dcache read of 0x20 -> read response data = 0xDEAD_BEEF_0000_0001.
REQ-032 icache and dcache requests in the same cycle -> icache responds in cycle 6, dcache responds in cycle 13; dcache_req_ready is low until the dcache slot is served.
REQ-033 rst_aH asserted during WAIT of a dcache write to 0x30 -> no resp_valid; block 0x30 unchanged; both ready outputs high after release.
REQ-034 dcache read at addr NUM_BLOCKS+5 -> returns the contents of block 5.
REQ-035 With MEM_CTRL_PERF_EN: 3 icache reads and 2 dcache writes -> icache_req_count = 3, dcache_req_count = 2; counts return to 0 after rst_aH.
